// File: rtl/single_cycle_core_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : single_cycle_core_pkg
//  Purpose  : Opcode/funct constants and ALU control encoding for the core.
//  Revision : 1.0 - initial release
// ============================================================================
package single_cycle_core_pkg;

    localparam logic [5:0] c_OP_RTYPE = 6'b000000;
    localparam logic [5:0] c_OP_LW    = 6'b100011;
    localparam logic [5:0] c_OP_SW    = 6'b101011;
    localparam logic [5:0] c_OP_BEQ   = 6'b000100;
    localparam logic [5:0] c_OP_ADDI  = 6'b001000;
    localparam logic [5:0] c_OP_J     = 6'b000010;

    localparam logic [5:0] c_FN_ADD = 6'b100000;
    localparam logic [5:0] c_FN_SUB = 6'b100010;
    localparam logic [5:0] c_FN_AND = 6'b100100;
    localparam logic [5:0] c_FN_OR  = 6'b100101;
    localparam logic [5:0] c_FN_SLT = 6'b101010;

    typedef enum logic [2:0] {
        ALU_AND = 3'b000,
        ALU_OR  = 3'b001,
        ALU_ADD = 3'b010,
        ALU_SUB = 3'b110,
        ALU_SLT = 3'b111
    } alu_ctrl_t;

    function automatic logic [31:0] sign_extend(input logic [15:0] imm);
        return {{16{imm[15]}}, imm};
    endfunction

endpackage
`default_nettype wire

// File: rtl/single_cycle_regfile.sv
`default_nettype none
// ============================================================================
//  Module   : single_cycle_regfile
//  Purpose  : 32x32 register file, two async read ports, one write port,
//             register 0 hardwired to zero.
//  Revision : 1.0 - initial release
// ============================================================================
module single_cycle_regfile (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_we,
    input  logic [4:0]  i_wa,
    input  logic [31:0] i_wd,
    input  logic [4:0]  i_ra1,
    input  logic [4:0]  i_ra2,
    output logic [31:0] o_rd1,
    output logic [31:0] o_rd2
);

    logic [31:0] r_regs [0:31];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                r_regs[i] <= '0;
            end
        end else if (i_we && (i_wa != 5'd0)) begin
            r_regs[i_wa] <= i_wd;
        end
    end

    // Reads see the pre-edge contents; no write-through bypass.
    assign o_rd1 = (i_ra1 == 5'd0) ? 32'd0 : r_regs[i_ra1];
    assign o_rd2 = (i_ra2 == 5'd0) ? 32'd0 : r_regs[i_ra2];

endmodule
`default_nettype wire

// File: rtl/single_cycle_core.sv
`default_nettype none
// ============================================================================
//  Module   : single_cycle_core
//  Purpose  : Single-cycle 32-bit MIPS-subset core (controller + datapath).
//  Revision : 1.0 - initial release
// ============================================================================
module single_cycle_core
    import single_cycle_core_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        CLK,
    input  logic        Reset,
    input  logic [31:0] Instr,
    input  logic [31:0] ReadData,
    output logic [31:0] ALUResult,
    output logic [31:0] PC,
    output logic [31:0] WriteData,
    output logic        MemWrite
);

    logic [5:0]  w_op;
    logic [5:0]  w_funct;
    logic [4:0]  w_rs;
    logic [4:0]  w_rt;
    logic [4:0]  w_rd;
    logic [31:0] w_sign_imm;

    logic        w_reg_write;
    logic        w_reg_dst;
    logic        w_alu_src;
    logic        w_mem_write;
    logic        w_mem_to_reg;
    logic        w_branch;
    logic        w_jump;
    logic        w_illegal;
    alu_ctrl_t   w_alu_ctrl;

    logic [31:0] r_pc;
    logic [31:0] w_pc_plus4;
    logic [31:0] w_pc_branch;
    logic [31:0] w_pc_jump;
    logic [31:0] w_pc_next;
    logic [31:0] w_src_a;
    logic [31:0] w_rd2;
    logic [31:0] w_src_b;
    logic [31:0] w_alu_out;
    logic [31:0] w_wr_data;
    logic [4:0]  w_wr_addr;
    logic        w_zero;

    assign w_op       = Instr[31:26];
    assign w_rs       = Instr[25:21];
    assign w_rt       = Instr[20:16];
    assign w_rd       = Instr[15:11];
    assign w_funct    = Instr[5:0];
    assign w_sign_imm = sign_extend(Instr[15:0]);

    // Controller: main decoder and ALU decoder folded together.
    always_comb begin
        w_reg_write  = 1'b0;
        w_reg_dst    = 1'b0;
        w_alu_src    = 1'b0;
        w_mem_write  = 1'b0;
        w_mem_to_reg = 1'b0;
        w_branch     = 1'b0;
        w_jump       = 1'b0;
        w_illegal    = 1'b0;
        w_alu_ctrl   = ALU_ADD;
        case (w_op)
            c_OP_RTYPE: begin
                w_reg_write = 1'b1;
                w_reg_dst   = 1'b1;
                case (w_funct)
                    c_FN_ADD: w_alu_ctrl = ALU_ADD;
                    c_FN_SUB: w_alu_ctrl = ALU_SUB;
                    c_FN_AND: w_alu_ctrl = ALU_AND;
                    c_FN_OR:  w_alu_ctrl = ALU_OR;
                    c_FN_SLT: w_alu_ctrl = ALU_SLT;
                    default: begin
                        w_reg_write = 1'b0;
                        w_illegal   = 1'b1;
                    end
                endcase
            end
            c_OP_LW: begin
                w_reg_write  = 1'b1;
                w_alu_src    = 1'b1;
                w_mem_to_reg = 1'b1;
            end
            c_OP_SW: begin
                w_alu_src   = 1'b1;
                w_mem_write = 1'b1;
            end
            c_OP_BEQ: begin
                w_branch   = 1'b1;
                w_alu_ctrl = ALU_SUB;
            end
            c_OP_ADDI: begin
                w_reg_write = 1'b1;
                w_alu_src   = 1'b1;
            end
            c_OP_J: begin
                w_jump = 1'b1;
            end
            default: begin
                w_illegal = 1'b1;
            end
        endcase
    end

    assign w_wr_addr = w_reg_dst ? w_rd : w_rt;
    assign w_wr_data = w_mem_to_reg ? ReadData : ALUResult;

    single_cycle_regfile u_regfile (
        .clk   (CLK),
        .rst   (Reset),
        .i_we  (w_reg_write),
        .i_wa  (w_wr_addr),
        .i_wd  (w_wr_data),
        .i_ra1 (w_rs),
        .i_ra2 (w_rt),
        .o_rd1 (w_src_a),
        .o_rd2 (w_rd2)
    );

    assign w_src_b = w_alu_src ? w_sign_imm : w_rd2;

    always_comb begin
        w_alu_out = 32'd0;
        case (w_alu_ctrl)
            ALU_AND: w_alu_out = w_src_a & w_src_b;
            ALU_OR:  w_alu_out = w_src_a | w_src_b;
            ALU_ADD: w_alu_out = w_src_a + w_src_b;
            ALU_SUB: w_alu_out = w_src_a - w_src_b;
            ALU_SLT: w_alu_out = ($signed(w_src_a) < $signed(w_src_b)) ? 32'd1 : 32'd0;
            default: w_alu_out = 32'd0;
        endcase
    end

    // Undefined encodings behave as a NOP, including a zero ALU result.
    assign ALUResult = w_illegal ? 32'd0 : w_alu_out;
    assign w_zero    = (ALUResult == 32'd0);

    assign w_pc_plus4  = r_pc + 32'd4;
    assign w_pc_branch = w_pc_plus4 + (w_sign_imm << 2);
    assign w_pc_jump   = {w_pc_plus4[31:28], Instr[25:0], 2'b00};

    always_comb begin
        w_pc_next = w_pc_plus4;
        if (w_jump) begin
            w_pc_next = w_pc_jump;
        end else if (w_branch && w_zero) begin
            w_pc_next = w_pc_branch;
        end
    end

    always_ff @(posedge CLK) begin
        if (Reset) begin
            r_pc <= RESET_PC;
        end else begin
            r_pc <= w_pc_next;
        end
    end

    assign PC        = r_pc;
    assign WriteData = w_rd2;
    assign MemWrite  = w_mem_write & ~Reset;

endmodule
`default_nettype wire

// File: tb/tb_single_cycle_core.sv
`default_nettype none
// ============================================================================
//  Module   : tb_single_cycle_core
//  Purpose  : Directed self-checking bench for single_cycle_core.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_single_cycle_core;

    logic        clk;
    logic        rst;
    logic [31:0] instr;
    logic [31:0] read_data;
    logic [31:0] alu_result;
    logic [31:0] pc;
    logic [31:0] write_data;
    logic        mem_write;

    int checks   = 0;
    int failures = 0;

    single_cycle_core #(.RESET_PC(32'h0000_0000)) dut (
        .CLK       (clk),
        .Reset     (rst),
        .Instr     (instr),
        .ReadData  (read_data),
        .ALUResult (alu_result),
        .PC        (pc),
        .WriteData (write_data),
        .MemWrite  (mem_write)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] enc_r(input logic [5:0] fn, input logic [4:0] rd,
                                          input logic [4:0] rs, input logic [4:0] rt);
        return {6'b000000, rs, rt, rd, 5'd0, fn};
    endfunction

    function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rt,
                                          input logic [4:0] rs, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    function automatic logic [31:0] enc_j(input logic [25:0] target);
        return {6'b000010, target};
    endfunction

    task automatic apply(input logic [31:0] ins, input logic [31:0] rdata);
        instr     = ins;
        read_data = rdata;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Execute one instruction: check ALU result and MemWrite, then next PC.
    task automatic exec(input string tag, input logic [31:0] ins, input logic [31:0] exp_alu,
                        input logic [31:0] exp_next_pc);
        apply(ins, 32'd0);
        check_eq({tag, ".alu"}, alu_result, exp_alu);
        check_eq({tag, ".memwrite"}, {31'd0, mem_write}, 32'd0);
        tick();
        check_eq({tag, ".next_pc"}, pc, exp_next_pc);
    endtask

    initial begin
        rst       = 1'b1;
        instr     = 32'd0;
        read_data = 32'd0;
        tick();
        rst = 1'b0;
        check_eq("reset.pc", pc, 32'h0);

        exec("rd_zero",  enc_r(6'b100000, 5'd9, 5'd10, 5'd11), 32'h0, 32'h04);
        exec("addi1",    enc_i(6'b001000, 5'd1, 5'd0, 16'd5), 32'h5, 32'h08);
        exec("addi2",    enc_i(6'b001000, 5'd2, 5'd0, 16'hFFFD), 32'hFFFF_FFFD, 32'h0C);
        exec("add3",     enc_r(6'b100000, 5'd3, 5'd1, 5'd2), 32'h2, 32'h10);
        exec("sub4",     enc_r(6'b100010, 5'd4, 5'd1, 5'd2), 32'h8, 32'h14);
        exec("slt5",     enc_r(6'b101010, 5'd5, 5'd2, 5'd1), 32'h1, 32'h18);

        apply(enc_i(6'b101011, 5'd1, 5'd0, 16'd4), 32'd0);
        check_eq("sw.memwrite", {31'd0, mem_write}, 32'd1);
        check_eq("sw.alu", alu_result, 32'h4);
        check_eq("sw.wdata", write_data, 32'h5);
        tick();

        apply(enc_i(6'b100011, 5'd6, 5'd0, 16'd4), 32'h1234);
        check_eq("lw.memwrite", {31'd0, mem_write}, 32'd0);
        check_eq("lw.alu", alu_result, 32'h4);
        tick();
        check_eq("lw.next_pc", pc, 32'h20);

        exec("beq_taken", enc_i(6'b000100, 5'd1, 5'd1, 16'd2), 32'h0, 32'h2C);
        exec("add7_lw",   enc_r(6'b100000, 5'd7, 5'd6, 5'd0), 32'h1234, 32'h30);
        exec("beq_not",   enc_i(6'b000100, 5'd2, 5'd1, 16'd2), 32'h8, 32'h34);
        exec("addi10",    enc_i(6'b001000, 5'd10, 5'd0, 16'd12), 32'hC, 32'h38);
        exec("addi11",    enc_i(6'b001000, 5'd11, 5'd0, 16'd10), 32'hA, 32'h3C);
        exec("and12",     enc_r(6'b100100, 5'd12, 5'd10, 5'd11), 32'h8, 32'h40);
        exec("or13",      enc_r(6'b100101, 5'd13, 5'd10, 5'd11), 32'hE, 32'h44);

        apply(enc_j(26'h40), 32'd0);
        tick();
        check_eq("j_first.next_pc", pc, 32'h100);
        apply(enc_j(26'h40), 32'd0);
        tick();
        check_eq("j_self.next_pc", pc, 32'h100);

        exec("addi_r0",   enc_i(6'b001000, 5'd0, 5'd0, 16'd7), 32'h7, 32'h104);
        exec("add8_r0",   enc_r(6'b100000, 5'd8, 5'd0, 5'd0), 32'h0, 32'h108);
        exec("illegal_op", {6'b111111, 5'd1, 5'd2, 16'd1}, 32'h0, 32'h10C);
        exec("chk_r2",    enc_r(6'b100000, 5'd14, 5'd2, 5'd0), 32'hFFFF_FFFD, 32'h110);
        exec("bad_funct", enc_r(6'b100001, 5'd3, 5'd1, 5'd1), 32'h0, 32'h114);
        exec("chk_r3",    enc_r(6'b100000, 5'd15, 5'd3, 5'd0), 32'h2, 32'h118);

        // Mid-run reset: stores and register writes must be suppressed.
        rst = 1'b1;
        apply(enc_i(6'b101011, 5'd1, 5'd0, 16'd4), 32'd0);
        check_eq("rst_sw.memwrite", {31'd0, mem_write}, 32'd0);
        tick();
        apply(enc_i(6'b001000, 5'd20, 5'd0, 16'd77), 32'd0);
        tick();
        rst = 1'b0;
        check_eq("rst_mid.pc", pc, 32'h0);
        exec("rst_r20",  enc_r(6'b100000, 5'd21, 5'd20, 5'd0), 32'h0, 32'h04);
        exec("rst_r1r2", enc_r(6'b100000, 5'd16, 5'd1, 5'd2), 32'h0, 32'h08);
        exec("rst_r6r13", enc_r(6'b100101, 5'd17, 5'd6, 5'd13), 32'h0, 32'h0C);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
